latch_wr_arbiter: RTL
=====================

Name: latch_wr_arbiter

Overview:
Arbitrates write access from NUM_REQ requesters to one shared, level-sensitive D-latch storage word. It sequences the latch gate from a flop, with a setup cycle before the gate opens and a hold cycle after it closes. This keeps latch data stable across every gate edge. It sits between requesting blocks and the shared latch: latch_en drives the latch gate and latch_d drives the latch data input.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
DATA_W, 8, width of the latched word
OPEN_CYC, 2, number of cycles latch_en stays high per write (>=1)

Ports:
clk  input  1  single system clock; all state updates on its rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NUM_REQ  per-requester write request, level; held until matching done
wr_data  input  NUM_REQ*DATA_W  packed write data; requester i uses [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot grant, zero when idle
done  output  NUM_REQ  one-cycle completion pulse to the granted requester
latch_en  output  1  gate to the shared D latch (transparent when 1)
latch_d  output  DATA_W  data to the shared D latch
busy  output  1  high while a write transaction is in progress

Behaviour:
- Reset values (rst=0, asynchronous): state IDLE, gnt=0, done=0, latch_en=0, latch_d=0, busy=0, round-robin pointer=0, open counter=0.
- All outputs are registered. latch_en must come directly from a flop, with no combinational gating.
- FSM states:
  - IDLE
    - If req is nonzero, pick a winner and go to SETUP.
    - Winner rule: the first set bit at or after the pointer, searching upward and wrapping.
    - On entry to SETUP: gnt[winner]=1, busy=1, and latch_d captures wr_data[winner].
    - If req is zero, stay in IDLE.
  - SETUP
    - Lasts one cycle with latch_en=0.
    - Then go to OPEN with latch_en=1 and the counter loaded.
  - OPEN
    - latch_en=1 for exactly OPEN_CYC cycles. Counter width is $clog2(OPEN_CYC+1).
    - Then go to HOLD.
  - HOLD
    - Lasts one cycle: latch_en=0, latch_d unchanged, done[winner]=1.
    - Then go to IDLE: gnt=0, busy=0, done=0, pointer=(winner+1) mod NUM_REQ.
- Data handling:
  - latch_d is constant from grant through HOLD.
  - Changes to wr_data after the capture are ignored.
  - latch_d keeps its last value while IDLE.
- Timing:
  - gnt rises 1 cycle after req is sampled in IDLE.
  - latch_en rises 1 cycle after gnt.
  - done pulses OPEN_CYC+1 cycles after gnt rises.
- Throughput: the block spends at least one cycle in IDLE between transactions, so back-to-back grants are OPEN_CYC+3 cycles apart.
- Requester dropping req mid-transaction: the transaction still completes and done still pulses.
- Requester holding req after done: it is re-arbitrated in IDLE, and round-robin gives the other requesters priority.
- Only one transaction is ever in flight. Requests that arrive while busy wait until IDLE.
- Reset mid-transaction: all outputs return immediately to their reset values. latch_en falls asynchronously, no done is issued, and the pointer returns to 0.
- NUM_REQ=1: the pointer is constant 0 and behaviour is otherwise identical.

Optional Feature:
LATCH_ARB_FIXED_PRI_EN
- Defined: fixed priority; the lowest-index asserted req always wins, and the pointer is neither used nor updated.
- Undefined (default): round-robin as described under Behaviour.
- FSM timing is identical in both builds.

Test Plan:
1. Reset
   - Stimulus: rst=0 with req=4'b1111 driven.
   - Required: gnt=0, done=0, latch_en=0, latch_d=0, busy=0.
   - Then release rst: gnt=4'b0001 one cycle later.
2. Single write (OPEN_CYC=2)
   - Stimulus: req[2]=1, wr_data[2]=8'hA5.
   - Required: gnt=4'b0100 at T.
   - latch_en=1 at T+1 and T+2, 0 at T+3.
   - latch_d=8'hA5 from T through T+3.
   - done[2] pulses at T+3 only.
   - busy=0 at T+4.
3. Round-robin
   - Stimulus: req=4'b1111 held throughout.
   - Required: grant order 0,1,2,3,0, with gnt rising edges 5 cycles apart (OPEN_CYC=2).
4. Data stability
   - Stimulus: wr_data[0] changes from 8'h11 to 8'h3C while in OPEN.
   - Required: latch_d stays 8'h11 through HOLD.
5. Reset mid-OPEN
   - Stimulus: rst=0 while latch_en=1.
   - Required: latch_en falls immediately and no done pulse is issued.
   - After release with req=4'b1010 held: gnt=4'b0010 (pointer restarted at 0).
6. Fixed-priority build
   - Stimulus: compile with LATCH_ARB_FIXED_PRI_EN; hold req=4'b0110.
   - Required: requester 1 is granted on every transaction and requester 2 never is.

Source files
------------

// File: rtl/latch_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : latch_wr_arbiter
// Brief   : Arbitrates NUM_REQ writers onto one shared D-latch word with a
//           setup cycle before and a hold cycle after the flop-driven gate.
//           Define LATCH_ARB_FIXED_PRI_EN for fixed (lowest-index) priority.
// Revision: 1.0 - initial release
// ============================================================================
module latch_wr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int OPEN_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      latch_en,
    output logic [DATA_W-1:0]         latch_d,
    output logic                      busy
);

    localparam int C_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int C_CNT_W = $clog2(OPEN_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_OPEN  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t               state_q,    state_d;
    logic [NUM_REQ-1:0]   gnt_q,      gnt_d;
    logic [NUM_REQ-1:0]   done_q,     done_d;
    logic                 latch_en_q, latch_en_d;
    logic [DATA_W-1:0]    latch_d_q,  latch_d_d;
    logic                 busy_q,     busy_d;
    logic [C_PTR_W-1:0]   ptr_q,      ptr_d;
    logic [C_PTR_W-1:0]   win_q,      win_d;
    logic [C_CNT_W-1:0]   cnt_q,      cnt_d;

    logic [C_PTR_W-1:0]   pick;
    logic [DATA_W-1:0]    pick_data;
    int                   arb_start;

    // Two descending passes: the lowest asserted index is the wrap-around
    // fallback, overridden by the lowest asserted index at or above the start.
    always_comb begin
`ifdef LATCH_ARB_FIXED_PRI_EN
        arb_start = 0;
`else
        arb_start = int'(ptr_q);
`endif
        pick      = '0;
        pick_data = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick      = C_PTR_W'(i);
                pick_data = wr_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= arb_start)) begin
                pick      = C_PTR_W'(i);
                pick_data = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        latch_en_d = latch_en_q;
        latch_d_d  = latch_d_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d   = S_SETUP;
                    gnt_d     = NUM_REQ'(1) << pick;
                    busy_d    = 1'b1;
                    latch_d_d = pick_data;
                    win_d     = pick;
                end
            end
            S_SETUP: begin
                state_d    = S_OPEN;
                latch_en_d = 1'b1;
                cnt_d      = C_CNT_W'(OPEN_CYC);
            end
            S_OPEN: begin
                if (cnt_q == C_CNT_W'(1)) begin
                    state_d    = S_HOLD;
                    latch_en_d = 1'b0;
                    done_d     = gnt_q;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
`ifndef LATCH_ARB_FIXED_PRI_EN
                if (win_q == C_PTR_W'(NUM_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = win_q + C_PTR_W'(1);
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            latch_en_q <= 1'b0;
            latch_d_q  <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            latch_en_q <= latch_en_d;
            latch_d_q  <= latch_d_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign latch_en = latch_en_q;
    assign latch_d  = latch_d_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire
